apb_master_requester: RTL and testbench
=======================================

// Module: apb_master_requester
// PURPOSE
//   APB (APB4) requester. Accepts one command at a time on a valid/ready port,
//   runs the APB SETUP and ACCESS phases on PCLK, and waits for the completer's
//   PREADY. It returns read data and error status on a valid/ready response port.
//   It is the initiating end of the APB link that the bench's slave driver and
//   monitor sit on. It also serves as a reference APB stimulus source for the
//   AHB-to-APB bridge environment.
// PARAMETERS
//   PDATA_SIZE      32  width of PADDR/PWDATA/PRDATA; PSTRB width = PDATA_SIZE/8
//   TIMEOUT_CYCLES  16  max ACCESS cycles without PREADY before abort; 0 = no timeout
// PORTS
//   PCLK         in   1             clock; all logic on the rising edge
//   PRESET       in   1             asynchronous, active-high reset
//   cmd_valid    in   1             command present
//   cmd_ready    out  1             block idle and able to accept a command
//   cmd_write    in   1             1 = write, 0 = read
//   cmd_addr     in   PDATA_SIZE    transfer address
//   cmd_wdata    in   PDATA_SIZE    write data
//   cmd_strb     in   PDATA_SIZE/8  write byte strobes
//   cmd_prot     in   3             protection attributes
//   rsp_valid    out  1             response present
//   rsp_ready    in   1             response consumed
//   rsp_rdata    out  PDATA_SIZE    read data; 0 for writes and timeouts
//   rsp_err      out  1             PSLVERR seen, or timeout
//   rsp_timeout  out  1             transfer aborted by timeout
//   PSEL/PENABLE/PWRITE out 1; PPROT out 3; PADDR/PWDATA out PDATA_SIZE;
//   PSTRB out PDATA_SIZE/8; PRDATA in PDATA_SIZE; PREADY/PSLVERR in 1
// BEHAVIOUR
//   - Reset: PRESET=1 clears all outputs to 0 and sets state to IDLE.
//     The reset takes effect immediately and does not wait for PCLK.
//     Reset mid-transfer drops PSEL and PENABLE at once. The in-flight
//     transfer is discarded and no rsp_valid is produced.
//   - States: IDLE -> SETUP -> ACCESS -> RESP -> IDLE. All outputs are
//     registered. cmd_ready = (state==IDLE).
//   - IDLE: on cmd_valid&&cmd_ready, capture the command into PADDR, PWRITE,
//     PWDATA, PPROT and PSTRB. Set PSEL=1, PENABLE=0, go to SETUP.
//     PSTRB is forced to 0 on reads.
//   - SETUP: lasts exactly 1 cycle. Then PENABLE=1, wait_cnt=0, go to ACCESS.
//   - ACCESS: sample the completer at each rising edge.
//     * If PREADY=1: rsp_rdata = PRDATA (reads only), rsp_err = PSLVERR,
//       rsp_timeout = 0. Set PSEL=PENABLE=0 and go to RESP.
//     * Else if TIMEOUT_CYCLES!=0 and wait_cnt==TIMEOUT_CYCLES-1: set
//       PSEL=PENABLE=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
//     * Else wait_cnt++. Counter width is clog2(TIMEOUT_CYCLES+1); it never wraps.
//   - PSLVERR and PRDATA are ignored unless PSEL, PENABLE and PREADY are all 1.
//   - PADDR, PWRITE, PWDATA, PSTRB and PPROT stay stable from SETUP through the
//     last ACCESS cycle. After the transfer they keep their values; only PSEL
//     and PENABLE return to 0.
//   - RESP: rsp_valid=1 and rsp_* stay stable until rsp_ready=1, then go to IDLE.
//     No new command is accepted while in RESP.
//   - Latency: command accepted at edge N gives SETUP in cycle N+1 and ACCESS
//     from N+2. With zero waits, rsp_valid is 1 in cycle N+3. Back-to-back
//     transfers are at minimum 4 cycles apart.
//   - cmd_* inputs are don't-care while cmd_ready=0.
// TESTING
//   1 Reset: hold PRESET=1 mid-stream -> all outputs 0. After release,
//     cmd_ready=1 and PSEL=0.
//   2 Zero-wait write: addr 0x10, wdata 0xDEADBEEF, strb 0xF, PREADY=1 ->
//     cycle N+1 has PSEL=1, PENABLE=0; N+2 has PENABLE=1; N+3 has rsp_valid=1,
//     rsp_err=0, rsp_rdata=0.
//   3 Read, 3 waits: addr 0x20; PREADY=1 with PRDATA=0x12345678 only in the 4th
//     ACCESS cycle -> PENABLE=1 for 4 cycles, PSTRB=0, rsp_rdata=0x12345678.
//   4 Slave error: read with PREADY=1, PSLVERR=1 -> rsp_err=1, rsp_timeout=0.
//     PSLVERR pulsed while PREADY=0 is ignored.
//   5 Timeout: TIMEOUT_CYCLES=16, PREADY held 0 -> PENABLE=1 for exactly 16
//     cycles, then PSEL=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//   6 Backpressure + reset: rsp_ready=0 for 5 cycles -> rsp_valid and data held,
//     cmd_ready=0. PRESET pulsed in ACCESS -> PSEL/PENABLE go 0 before the next
//     edge, and rsp_valid never asserts.

Source files
------------

// File: rtl/apb_master_requester_if.sv
// Bundle of the command/response handshakes and the APB4 bus seen by the requester.
// The master modport is the requester's view; the slave modport is the completer/driver side.
interface apb_master_requester_if #(
    parameter int PDATA_SIZE = 32
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [PDATA_SIZE-1:0]   cmd_addr;
    logic [PDATA_SIZE-1:0]   cmd_wdata;
    logic [PDATA_SIZE/8-1:0] cmd_strb;
    logic [2:0]              cmd_prot;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [PDATA_SIZE-1:0]   rsp_rdata;
    logic                    rsp_err;
    logic                    rsp_timeout;

    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [2:0]              PPROT;
    logic [PDATA_SIZE-1:0]   PADDR;
    logic [PDATA_SIZE-1:0]   PWDATA;
    logic [PDATA_SIZE/8-1:0] PSTRB;
    logic [PDATA_SIZE-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output PSEL, PENABLE, PWRITE, PPROT, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  PSEL, PENABLE, PWRITE, PPROT, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master_requester.sv
// APB4 requester: one command at a time through SETUP/ACCESS, optional ACCESS timeout,
// result held on a valid/ready response port until consumed.
module apb_master_requester #(
    parameter int PDATA_SIZE     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    apb_master_requester_if.master bus
);

    localparam int STRB_W = PDATA_SIZE / 8;
    // A zero timeout still needs a legal (1-bit) counter even though it is never compared.
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]            state;
    logic [CNT_W-1:0]      wait_cnt;

    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [2:0]            pprot_q;
    logic [PDATA_SIZE-1:0] paddr_q;
    logic [PDATA_SIZE-1:0] pwdata_q;
    logic [STRB_W-1:0]     pstrb_q;

    logic                  rsp_valid_q;
    logic [PDATA_SIZE-1:0] rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  rsp_timeout_q;

    logic                  completer_done;

    // The completer's response is only meaningful in a genuine ACCESS cycle.
    assign completer_done = psel_q && penable_q && bus.PREADY;

    // Transfer sequencing: every bus and response output is a register written here.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pprot_q       <= '0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        paddr_q   <= bus.cmd_addr;
                        pwrite_q  <= bus.cmd_write;
                        pwdata_q  <= bus.cmd_wdata;
                        pprot_q   <= bus.cmd_prot;
                        pstrb_q   <= bus.cmd_write ? bus.cmd_strb : '0;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state     <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    penable_q <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (completer_done) begin
                        rsp_rdata_q   <= pwrite_q ? '0 : bus.PRDATA;
                        rsp_err_q     <= bus.PSLVERR;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state         <= ST_RESP;
                    end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST)) begin
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state         <= ST_RESP;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Gated by PRESET so that every output reads 0 while reset is held.
    assign bus.cmd_ready   = (state == ST_IDLE) && !PRESET;

    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PPROT       = pprot_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.PSTRB       = pstrb_q;

    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_requester.sv
// Self-checking bench for apb_master_requester: directed vector table, random transfers
// against a transfer-level model, and hand-written reset sequences.
module tb_apb_master_requester;

    localparam int PDATA_SIZE = 32;
    localparam int TO         = 16;

    logic PCLK = 1'b0;
    logic PRESET;

    always #5 PCLK = ~PCLK;

    apb_master_requester_if #(.PDATA_SIZE(PDATA_SIZE)) bus ();

    apb_master_requester #(
        .PDATA_SIZE    (PDATA_SIZE),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;
        logic        slverr;
        logic [31:0] rdata;
        int          rspDelay;
        int          expAccess;
        logic        expErr;
        logic        expTimeout;
        logic [31:0] expRdata;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[8];

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Transfer-level expectation: how many ACCESS cycles and what response a transfer yields.
    function automatic vec_t modelExpect(input vec_t v);
        vec_t r;
        bit   timedOut;
        r            = v;
        timedOut     = (v.waits >= TO);
        r.expAccess  = timedOut ? TO : v.waits + 1;
        r.expTimeout = timedOut;
        r.expErr     = timedOut || v.slverr;
        r.expRdata   = (timedOut || v.write) ? 32'h0 : v.rdata;
        return r;
    endfunction

    task automatic applyStimulus(input vec_t v);
        int          guard;
        int          acc;
        logic [3:0]  expStrb;
        expStrb = v.write ? v.strb : 4'h0;

        guard = 0;
        while (!bus.cmd_ready && guard < 50) begin
            tick();
            guard++;
        end
        checkOutput("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);

        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.write;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        bus.cmd_strb  = v.strb;
        bus.cmd_prot  = v.prot;
        bus.rsp_ready = 1'b0;
        tick();

        // Command inputs are don't-care while busy; scramble them.
        bus.cmd_valid = 1'($urandom);
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
        bus.cmd_strb  = 4'($urandom);
        bus.cmd_prot  = 3'($urandom);

        checkOutput("setup_psel", 64'(bus.PSEL), 64'd1);
        checkOutput("setup_penable", 64'(bus.PENABLE), 64'd0);
        checkOutput("setup_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        checkOutput("setup_paddr", 64'(bus.PADDR), 64'(v.addr));
        checkOutput("setup_pwrite", 64'(bus.PWRITE), 64'(v.write));
        checkOutput("setup_pwdata", 64'(bus.PWDATA), 64'(v.wdata));
        checkOutput("setup_pstrb", 64'(bus.PSTRB), 64'(expStrb));
        checkOutput("setup_pprot", 64'(bus.PPROT), 64'(v.prot));
        tick();

        acc = 0;
        while (bus.PSEL && bus.PENABLE && acc < 40) begin
            checkOutput("access_paddr_stable", 64'(bus.PADDR), 64'(v.addr));
            checkOutput("access_pstrb_stable", 64'(bus.PSTRB), 64'(expStrb));
            checkOutput("access_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            bus.PREADY  = (acc == v.waits);
            bus.PSLVERR = bus.PREADY ? v.slverr : 1'b1;
            bus.PRDATA  = bus.PREADY ? v.rdata : $urandom;
            acc++;
            tick();
        end
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = $urandom;

        checkOutput("access_cycles", 64'(acc), 64'(v.expAccess));
        checkOutput("resp_psel", 64'(bus.PSEL), 64'd0);
        checkOutput("resp_penable", 64'(bus.PENABLE), 64'd0);
        checkOutput("resp_valid", 64'(bus.rsp_valid), 64'd1);
        checkOutput("resp_err", 64'(bus.rsp_err), 64'(v.expErr));
        checkOutput("resp_timeout", 64'(bus.rsp_timeout), 64'(v.expTimeout));
        checkOutput("resp_rdata", 64'(bus.rsp_rdata), 64'(v.expRdata));
        checkOutput("resp_paddr_hold", 64'(bus.PADDR), 64'(v.addr));

        for (int i = 0; i < v.rspDelay; i++) begin
            tick();
            checkOutput("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            checkOutput("bp_rsp_rdata", 64'(bus.rsp_rdata), 64'(v.expRdata));
            checkOutput("bp_rsp_err", 64'(bus.rsp_err), 64'(v.expErr));
            checkOutput("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        end

        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        checkOutput("done_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("done_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;

        PRESET        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.cmd_prot  = '0;
        bus.rsp_ready = 1'b0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;

        //               wr addr      wdata         strb  prot  wt  err rdata         bp  acc err to  rdata
        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'h0,  0, 1'b0, 32'h0,        0,  1, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h20, 32'h0,        4'hF, 3'h2,  3, 1'b0, 32'h12345678, 0,  4, 1'b0, 1'b0, 32'h12345678};
        vecs[2] = '{1'b0, 32'h30, 32'h0,        4'h0, 3'h0,  0, 1'b1, 32'hAAAA5555, 0,  1, 1'b1, 1'b0, 32'hAAAA5555};
        vecs[3] = '{1'b0, 32'h40, 32'h0,        4'h0, 3'h0, 30, 1'b0, 32'hCAFEF00D, 0, 16, 1'b1, 1'b1, 32'h0};
        vecs[4] = '{1'b1, 32'h50, 32'h11223344, 4'h3, 3'h5, 15, 1'b0, 32'h0,        0, 16, 1'b0, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 32'h54, 32'h55667788, 4'hC, 3'h0, 16, 1'b0, 32'h0,        0, 16, 1'b1, 1'b1, 32'h0};
        vecs[6] = '{1'b1, 32'h60, 32'hA5A5A5A5, 4'h1, 3'h7,  2, 1'b1, 32'h99,       5,  3, 1'b1, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 32'h64, 32'h0,        4'h0, 3'h0,  1, 1'b0, 32'h0BADF00D, 2,  2, 1'b0, 1'b0, 32'h0BADF00D};

        // Reset held from time zero: every output must read 0.
        #2;
        checkOutput("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        checkOutput("rst_psel", 64'(bus.PSEL), 64'd0);
        checkOutput("rst_penable", 64'(bus.PENABLE), 64'd0);
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("rst_paddr", 64'(bus.PADDR), 64'd0);
        tick();
        tick();
        PRESET = 1'b0;
        tick();
        checkOutput("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        checkOutput("post_rst_psel", 64'(bus.PSEL), 64'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
        end

        // Asynchronous reset in the middle of an ACCESS phase.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h44;
        bus.cmd_strb  = 4'h0;
        bus.cmd_prot  = 3'h1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("pre_rst_penable", 64'(bus.PENABLE), 64'd1);
        #3;
        PRESET = 1'b1;
        #1;
        checkOutput("mid_rst_psel", 64'(bus.PSEL), 64'd0);
        checkOutput("mid_rst_penable", 64'(bus.PENABLE), 64'd0);
        checkOutput("mid_rst_paddr", 64'(bus.PADDR), 64'd0);
        checkOutput("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        checkOutput("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        tick();
        tick();
        PRESET = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("after_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            checkOutput("after_rst_psel", 64'(bus.PSEL), 64'd0);
        end
        bus.rsp_ready = 1'b0;
        checkOutput("after_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // Random transfers scored against the transfer-level model.
        for (int n = 0; n < 24; n++) begin
            v.write    = 1'($urandom);
            v.addr     = $urandom;
            v.wdata    = $urandom;
            v.strb     = 4'($urandom);
            v.prot     = 3'($urandom);
            v.waits    = $urandom_range(0, 19);
            v.slverr   = ($urandom_range(0, 3) == 0);
            v.rdata    = $urandom;
            v.rspDelay = $urandom_range(0, 3);
            applyStimulus(modelExpect(v));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
